// File: rtl/reset_sequencer_if.sv
// Board-side signal bundle of the reset sequencer: raw lock/key/kick
// inputs towards the sequencer and the per-domain resets plus status back.
interface reset_sequencer_if #(
    parameter int NCH = 4
);
    logic           pll_locked;
    logic           ext_rst_n;
    logic           wdt_kick;
    logic [NCH-1:0] rst_out;
    logic           sys_ready;
    logic           wdt_fired;

    // Board / top-level side: drives the raw inputs, observes the resets.
    modport master (
        output pll_locked, ext_rst_n, wdt_kick,
        input  rst_out, sys_ready, wdt_fired
    );

    // Sequencer side.
    modport slave (
        input  pll_locked, ext_rst_n, wdt_kick,
        output rst_out, sys_ready, wdt_fired
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-channel power-on / fault reset sequencer.
// Holds NCH reset domains asserted until the PLL is locked and the debounced
// board key has been released for HOLD_CYCLES, then releases channel 0 first
// and each further channel STAGE_GAP cycles later. Loss of lock or a key
// press re-asserts every channel and restarts the sequence.
// Optional build macro RESET_SEQ_WDT_EN adds a RUN-state watchdog that forces
// a resequence after WDT_CYCLES edges without wdt_kick and sets a sticky
// wdt_fired flag; without it wdt_kick is ignored and wdt_fired is 0.
module reset_sequencer #(
    parameter int NCH         = 4,
    parameter int HOLD_CYCLES = 32,
    parameter int STAGE_GAP   = 16,
    parameter int DEBOUNCE    = 1024,
    parameter int WDT_CYCLES  = 65536
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP   > 1) ? $clog2(STAGE_GAP)   : 1;
    localparam int CNT_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
    localparam int DB_W   = (DEBOUNCE    > 1) ? $clog2(DEBOUNCE)    : 1;
    localparam int IDX_W  = (NCH         > 1) ? $clog2(NCH)         : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NCH-1:0]   rst_q, rst_d;
    logic             ready_q, ready_d;

    logic lock_meta, lock_s;
    logic key_meta, key_s;
    logic [DB_W-1:0] db_cnt;
    logic btn_db;
    logic ok;
    logic wdt_trip;
    logic fault;

    // Two-flop synchronisers for the asynchronous lock and key inputs.
    always_ff @(posedge clk) begin
        // NOTE: registers are always written with <= so every flop samples
        // the pre-edge value of its neighbours, whatever the statement order.
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            key_meta  <= 1'b1;
            key_s     <= 1'b1;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
            key_meta  <= bus.ext_rst_n;
            key_s     <= key_meta;
        end
    end

    // Key debouncer: btn_db follows ~key_s once the synchronised key has
    // disagreed with it for DEBOUNCE consecutive edges; any agreement
    // (i.e. any change back) restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (~key_s != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db <= ~key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign ok = lock_s & ~btn_db;

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_fired_q;

    // A kick on the timeout edge wins, so the trip requires no kick.
    assign wdt_trip = (state_q == S_RUN) && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

    // Watchdog: counts RUN edges since the last kick; the fired flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt     <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            if ((state_q != S_RUN) || bus.wdt_kick || wdt_trip) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
            if (wdt_trip) begin
                wdt_fired_q <= 1'b1;
            end
        end
    end

    assign bus.wdt_fired = wdt_fired_q;
`else
    logic unused_wdt_kick;

    assign unused_wdt_kick = bus.wdt_kick;
    assign wdt_trip        = 1'b0;
    assign bus.wdt_fired   = 1'b0;
`endif

    assign fault = ~ok | wdt_trip;

    // Sequencer state register together with its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and next-output logic of the release sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        case (state_q)
            S_HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
                idx_d   = '0;
                if (!ok) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (NCH == 1) begin
                        state_d = S_RUN;
                        rst_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        state_d  = S_RELEASE;
                        rst_d[0] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                if (fault) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    // Channels 0..idx+1 are released; earlier ones stay low.
                    for (int i = 0; i < NCH; i++) begin
                        if (i <= int'(idx_q) + 1) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    if (int'(idx_q) + 1 == NCH - 1) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RUN: begin
                if (fault) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign bus.rst_out   = rst_q;
    assign bus.sys_ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (NCH=4, HOLD=32, GAP=16,
// DEBOUNCE=8, WDT=100). A timeline model predicts the outputs every cycle;
// directed literal expectations pin the key release/fault edges.
// Build with RESET_SEQ_WDT_EN defined to exercise the watchdog.
module tb_reset_sequencer;

    localparam int NCH      = 4;
    localparam int HOLD     = 32;
    localparam int GAP      = 16;
    localparam int DEB      = 8;
    localparam int WDT      = 100;
    localparam int RUN_T    = (NCH - 1) * GAP;
`ifdef RESET_SEQ_WDT_EN
    localparam bit WDT_EN   = 1'b1;
`else
    localparam bit WDT_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   edge_no = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    reset_sequencer_if #(.NCH(NCH)) bus ();

    reset_sequencer #(
        .NCH(NCH), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
        .DEBOUNCE(DEB), .WDT_CYCLES(WDT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Edge numbering: edge 1 is the first rising edge with reset low.
    always @(posedge clk) begin
        if (reset) edge_no <= 0;
        else       edge_no <= edge_no + 1;
    end

    // ---------------- timeline model ----------------
    // t = edges since channel 0 was released (-1 while holding); channel i
    // is released once t >= i*GAP and RUN is t >= (NCH-1)*GAP.
    typedef struct {
        int l1, ls, k1, ks;   // synchroniser stages
        int btn, dis;         // debounced press, disagreeing-edge run
        int okrun;            // consecutive ok edges while holding
        int t;
        int wdt, fired;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.l1 = 0; m.ls = 0; m.k1 = 1; m.ks = 1;
        m.btn = 0; m.dis = 0; m.okrun = 0; m.t = -1;
        m.wdt = 0; m.fired = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, logic pll, logic key, logic kick);
        model_t n = m;
        bit ok     = (m.ls == 1) && (m.btn == 0);
        bit in_run = (m.t >= RUN_T);
        bit trip   = WDT_EN && in_run && !kick && (m.wdt == WDT - 1);
        if (m.t < 0) begin
            if (!ok) n.okrun = 0;
            else if (m.okrun == HOLD - 1) begin n.okrun = 0; n.t = 0; end
            else n.okrun = m.okrun + 1;
        end else if (!ok || trip) begin
            n.t = -1; n.okrun = 0;
        end else if (!in_run) begin
            n.t = m.t + 1;
        end
        n.wdt = (!in_run || kick || trip) ? 0 : m.wdt + 1;
        if (trip) n.fired = 1;
        if (((m.ks == 0) ? 1 : 0) != m.btn) begin
            n.dis = m.dis + 1;
            if (n.dis == DEB) begin n.btn = (m.ks == 0) ? 1 : 0; n.dis = 0; end
        end else begin
            n.dis = 0;
        end
        n.ls = m.l1; n.l1 = int'(pll);
        n.ks = m.k1; n.k1 = int'(key);
        return n;
    endfunction

    function automatic logic [NCH-1:0] exp_rst(int t);
        logic [NCH-1:0] r = '1;
        for (int i = 0; i < NCH; i++) if (t >= i * GAP) r[i] = 1'b0;
        return r;
    endfunction

    model_t m = model_reset();

    always @(posedge clk) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, bus.pll_locked, bus.ext_rst_n, bus.wdt_kick);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
        end
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("model rst_out",   32'(bus.rst_out),   32'(exp_rst(m.t)));
        check("model sys_ready", 32'(bus.sys_ready), 32'(m.t >= RUN_T));
        check("model wdt_fired", 32'(bus.wdt_fired), 32'(m.fired));
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_no < n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                $display("FAIL wait_edge timeout waiting for edge %0d", n);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic expect_at(input int n, input string name, input logic [NCH-1:0] r,
                             input logic rdy, input logic fired);
        wait_edge(n);
        check({name, " rst_out"},   32'(bus.rst_out),   32'(r));
        check({name, " sys_ready"}, 32'(bus.sys_ready), 32'(rdy));
        check({name, " wdt_fired"}, 32'(bus.wdt_fired), 32'(fired));
    endtask

    task automatic kick_at(input int n);
        wait_edge(n - 1);
        bus.wdt_kick = 1'b1;
        wait_edge(n);
        bus.wdt_kick = 1'b0;
    endtask

    initial begin
        bus.pll_locked = 1'b1;
        bus.ext_rst_n  = 1'b1;
        bus.wdt_kick   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rst_out",   32'(bus.rst_out),   32'hF);
        check("reset sys_ready", 32'(bus.sys_ready), 32'h0);
        check("reset wdt_fired", 32'(bus.wdt_fired), 32'h0);
        reset = 1'b0;

        // Power-up release timing.
        expect_at(33, "pre ch0",  4'b1111, 1'b0, 1'b0);
        expect_at(34, "ch0",      4'b1110, 1'b0, 1'b0);
        expect_at(49, "pre ch1",  4'b1110, 1'b0, 1'b0);
        expect_at(50, "ch1",      4'b1100, 1'b0, 1'b0);
        expect_at(66, "ch2",      4'b1000, 1'b0, 1'b0);
        expect_at(81, "pre ch3",  4'b1000, 1'b0, 1'b0);
        expect_at(82, "ch3",      4'b0000, 1'b1, 1'b0);

        // Lock loss in RUN, sampled at edge 100.
        wait_edge(99);  bus.pll_locked = 1'b0;
        expect_at(101, "lock lost +1", 4'b0000, 1'b1, 1'b0);
        expect_at(102, "lock lost +2", 4'b1111, 1'b0, 1'b0);
        bus.pll_locked = 1'b1;
        expect_at(135, "relock pre ch0", 4'b1111, 1'b0, 1'b0);
        expect_at(136, "relock ch0",     4'b1110, 1'b0, 1'b0);
        expect_at(184, "relock run",     4'b0000, 1'b1, 1'b0);

        // Short key press (5 edges) is filtered out.
        wait_edge(199); bus.ext_rst_n = 1'b0;
        wait_edge(204); bus.ext_rst_n = 1'b1;
        expect_at(215, "short press", 4'b0000, 1'b1, 1'b0);

        // Long key press (20 edges) re-asserts everything.
        wait_edge(219); bus.ext_rst_n = 1'b0;
        expect_at(229, "press settling", 4'b0000, 1'b1, 1'b0);
        expect_at(230, "press fault",    4'b1111, 1'b0, 1'b0);
        wait_edge(239); bus.ext_rst_n = 1'b1;
        expect_at(280, "key rel pre ch0", 4'b1111, 1'b0, 1'b0);
        expect_at(281, "key rel ch0",     4'b1110, 1'b0, 1'b0);

        // Lock loss while idx=1 in RELEASE.
        wait_edge(299); bus.pll_locked = 1'b0;
        expect_at(301, "idx1 before fault", 4'b1100, 1'b0, 1'b0);
        expect_at(302, "idx1 fault",        4'b1111, 1'b0, 1'b0);
        bus.pll_locked = 1'b1;
        expect_at(335, "restart pre ch0",   4'b1111, 1'b0, 1'b0);
        expect_at(336, "restart ch0 first", 4'b1110, 1'b0, 1'b0);

        // One-cycle block reset mid-RELEASE; numbering restarts.
        wait_edge(349); reset = 1'b1;
        @(negedge clk);
        check("midrel reset rst_out",   32'(bus.rst_out),   32'hF);
        check("midrel reset sys_ready", 32'(bus.sys_ready), 32'h0);
        reset = 1'b0;
        expect_at(34, "reseq ch0", 4'b1110, 1'b0, 1'b0);
        expect_at(82, "reseq run", 4'b0000, 1'b1, 1'b0);

        // Watchdog: kick every 50 edges, then stop after edge 400.
        for (int k = 100; k <= 400; k += 50) kick_at(k);
        expect_at(499, "wdt before trip", 4'b0000, 1'b1, 1'b0);
        if (WDT_EN) begin
            expect_at(500, "wdt trip",      4'b1111, 1'b0, 1'b1);
            expect_at(532, "wdt reseq ch0", 4'b1110, 1'b0, 1'b1);
            expect_at(580, "wdt reseq run", 4'b0000, 1'b1, 1'b1);
        end else begin
            expect_at(500, "no wdt trip",   4'b0000, 1'b1, 1'b0);
            expect_at(580, "no wdt run",    4'b0000, 1'b1, 1'b0);
        end
        wait_edge(599); reset = 1'b1;
        @(negedge clk);
        check("wdt flag cleared by reset", 32'(bus.wdt_fired), 32'h0);
        reset = 1'b0;
        wait_edge(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
